// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller for a single-cycle MIPS datapath.
// Serves one load/store at a time with a fixed latency and stalls the datapath meanwhile.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        addr_error,
  output logic [31:0] stall_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] word_reg;
  logic [31:0]   wdata_reg;
  logic          is_write_reg;
  logic [31:0]   read_data_reg;
  logic          done_reg;
  logic          addr_error_reg;
  logic [31:0]   stall_count_reg;

  logic [31:0]   mem [DEPTH_WORDS];

  logic req, illegal, accept, complete;

  assign req      = mem_read | mem_write;
  assign illegal  = (addr[1:0] != 2'b00) ||
                    ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                    (mem_read && mem_write);
  assign accept   = (state_reg == IDLE) && req;
  assign complete = (state_reg == BUSY) && (cnt_reg == 4'd0);

  assign stall       = !reset && (accept || (state_reg == BUSY));
  assign read_data   = read_data_reg;
  assign done        = done_reg;
  assign addr_error  = addr_error_reg;
  assign stall_count = stall_count_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) state_next = DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      word_reg        <= '0;
      wdata_reg       <= 32'd0;
      is_write_reg    <= 1'b0;
      read_data_reg   <= 32'd0;
      done_reg        <= 1'b0;
      addr_error_reg  <= 1'b0;
      stall_count_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      done_reg       <= (state_next == DONE);
      addr_error_reg <= accept && illegal;
      if (accept) begin
        word_reg     <= addr[AW+1:2];
        wdata_reg    <= write_data;
        is_write_reg <= mem_write;
      end
      // Illegal requests clear the load register; stores leave it untouched.
      if (accept && illegal)
        read_data_reg <= 32'd0;
      else if (complete && !is_write_reg)
        read_data_reg <= mem[word_reg];
      if (stall)
        stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  // Backing RAM has no reset; an access aborted by reset must not write.
  always_ff @(posedge clk) begin
    if (!reset && complete && is_write_reg)
      mem[word_reg] <= wdata_reg;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected completions are queued at issue
// and compared when done pulses, including stall length and stall_count.
module tb_data_mem_ctrl;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] addr, write_data;
  logic [31:0] read_data, stall_count;
  logic        stall, done, addr_error;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          stalls;
    logic [31:0] total;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_txn    = 0;
  int          stall_run = 0;
  logic [31:0] exp_total = 32'd0;
  logic [31:0] exp_rd    = 32'd0;
  logic [31:0] model [DEPTH];

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .stall(stall), .done(done), .addr_error(addr_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk) #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Issue one request; optionally scramble the inputs during the first BUSY cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic scramble);
    exp_t e;
    logic bad;
    logic seen;
    bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH)) || (rd && wr);
    if (bad)     exp_rd = 32'd0;
    else if (rd) exp_rd = model[a[9:2]];
    else         model[a[9:2]] = wd;
    e.data   = exp_rd;
    e.err    = bad;
    e.stalls = bad ? 1 : LAT + 1;
    exp_total = exp_total + 32'(e.stalls);
    e.total  = exp_total;
    sb.push_back(e);
    @(posedge clk) #1;
    mem_read = rd; mem_write = wr; addr = a; write_data = wd;
    if (scramble) begin
      @(posedge clk) #1;
      addr = 32'h28; write_data = 32'd0; mem_write = 1'b0; mem_read = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stall_run = 0;
    end else begin
      if (stall) stall_run++;
      if (done) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          n_txn++;
          check_eq("read_data",   read_data, mon_e.data);
          check_eq("addr_error",  32'(addr_error), 32'(mon_e.err));
          check_eq("stall_cycles", 32'(stall_run), 32'(mon_e.stalls));
          check_eq("stall_count", stall_count, mon_e.total);
          check_eq("stall_in_done", 32'(stall), 32'd0);
          $display("txn %0d: read_data=%h addr_error=%0d stalls=%0d stall_count=%0d",
                   n_txn, read_data, addr_error, stall_run, stall_count);
        end
        stall_run = 0;
      end else begin
        check_eq("err_without_done", 32'(addr_error), 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] ra, rd_val;
    reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h10; write_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_read_data", read_data, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_addr_error", 32'(addr_error), 32'd0);
    check_eq("rst_stall_count", stall_count, 32'd0);
    @(posedge clk) #1;
    reset = 1'b0; mem_read = 1'b0;

    access(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h10,  32'd0,        1'b0);
    access(1'b1, 1'b0, 32'h13,  32'd0,        1'b0);
    access(1'b1, 1'b0, 32'h400, 32'd0,        1'b0);
    access(1'b0, 1'b1, 32'h20,  32'h00000000, 1'b0);
    access(1'b0, 1'b1, 32'h28,  32'hA5A5A5A5, 1'b0);
    access(1'b0, 1'b1, 32'h30,  32'h0BADC0DE, 1'b0);
    access(1'b1, 1'b0, 32'h10,  32'd0,        1'b0);
    access(1'b1, 1'b1, 32'h20,  32'hFFFFFFFF, 1'b0);
    access(1'b1, 1'b0, 32'h20,  32'd0,        1'b0);
    access(1'b0, 1'b1, 32'h24,  32'h12345678, 1'b1);
    access(1'b1, 1'b0, 32'h24,  32'd0,        1'b0);
    access(1'b1, 1'b0, 32'h28,  32'd0,        1'b0);
    idle();

    // Reset lands in the last BUSY cycle of a store; the write must be dropped.
    @(posedge clk) #1;
    mem_write = 1'b1; addr = 32'h30; write_data = 32'hCAFEF00D;
    @(posedge clk) #1;
    mem_write = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("busy_rst_stall", 32'(stall), 32'd0);
    @(posedge clk) #1;
    check_eq("busy_rst_read_data", read_data, 32'd0);
    check_eq("busy_rst_done", 32'(done), 32'd0);
    check_eq("busy_rst_addr_error", 32'(addr_error), 32'd0);
    check_eq("busy_rst_stall_count", stall_count, 32'd0);
    reset = 1'b0;
    exp_total = 32'd0;
    exp_rd    = 32'd0;
    access(1'b1, 1'b0, 32'h30, 32'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra     = 32'h100 + (32'($urandom_range(0, 31)) << 2);
      rd_val = $urandom;
      access(1'b0, 1'b1, ra, rd_val, 1'b0);
      access(1'b1, 1'b0, ra, 32'd0,  1'b0);
    end
    idle();
    repeat (3) @(posedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
